// File: rtl/dp_mem_responder.sv
// Memory-side responder: arbitrates instruction and data requests from the
// datapath onto one single-port, fixed-latency RAM, one access at a time.
//
// state | meaning
// IDLE  | waiting for a request; data requests win over instruction fetches
// BUSY  | RAM access in flight, strobes held, latency counter running
// HIT   | one-cycle completion pulse on ihit or dhit
module dp_mem_responder #(
   parameter int LAT   = 2,
   parameter int CNT_W = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        halt,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   output logic        ramREN,
   output logic        ramWEN,
   input  logic [31:0] ramload
);

   typedef enum logic [1:0] {IDLE, BUSY, HIT} state_t;

   state_t             state, next_state;
   logic [CNT_W-1:0]   cnt;
   logic               sel_data;
   logic               accept_d, accept_i;
   logic               last_busy;

   // Byte offset bits are dropped when forming the RAM word address.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

   assign last_busy = (state == BUSY) && (cnt == '0);

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state and accept decode; data has strict priority over instruction.
   always_comb begin
      next_state = state;
      accept_d   = 1'b0;
      accept_i   = 1'b0;
      case (state)
         IDLE: begin
            if (dmemREN || dmemWEN) begin
               accept_d   = 1'b1;
               next_state = BUSY;
            end else if (imemREN && !halt) begin
               accept_i   = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY:    if (cnt == '0) next_state = HIT;
         HIT:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Transaction registers: RAM request capture, latency down-counter,
   // read-data capture on the last BUSY cycle and the registered hit pulses.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt      <= '0;
         sel_data <= 1'b0;
         ramaddr  <= '0;
         ramstore <= '0;
         ramREN   <= 1'b0;
         ramWEN   <= 1'b0;
         imemload <= '0;
         dmemload <= '0;
         ihit     <= 1'b0;
         dhit     <= 1'b0;
      end else begin
         ihit <= 1'b0;
         dhit <= 1'b0;
         if (accept_d) begin
            sel_data <= 1'b1;
            ramaddr  <= {dmemaddr[31:2], 2'b00};
            cnt      <= CNT_W'(LAT - 1);
            if (dmemWEN) begin
               ramWEN   <= 1'b1;
               ramREN   <= 1'b0;
               ramstore <= dmemstore;
            end else begin
               ramREN   <= 1'b1;
               ramWEN   <= 1'b0;
            end
         end else if (accept_i) begin
            sel_data <= 1'b0;
            ramaddr  <= {imemaddr[31:2], 2'b00};
            cnt      <= CNT_W'(LAT - 1);
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
         end else if (last_busy) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            ihit   <= !sel_data;
            dhit   <= sel_data;
            if (ramREN) begin
               if (sel_data) dmemload <= ramload;
               else          imemload <= ramload;
            end
         end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule
